// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and helpers for the APB master arbiter
package apb_arb_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Default ACCESS-phase timeout, in cycles
  localparam int TIMEOUT_CYC_DFLT = 16;

  // Timeout counter width: must hold the value TIMEOUT_CYC itself
  function automatic int to_cnt_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/apb_master_arb_rr_arbiter.sv
// rtl/apb_master_arb_rr_arbiter.sv - rotating-priority arbiter owning its pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          upd_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  // First set request at ptr, ptr+1, ... wrapping at N
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

  // Pointer moves one past the winner when the grant is taken
  always_comb begin
    ptr_d = ptr_q;
    if (upd_i && found) begin
      ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  // Pointer register; requester 0 has top priority out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - N-requester APB master with round-robin arbitration (optional APB_TIMEOUT_EN)
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("apb_master_arb: N_REQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               arb_upd;
  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               to_hit;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk_i   (pclk),
    .rst_i   (preset),
    .req_i   (req),
    .upd_i   (arb_upd),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = to_cnt_w(TIMEOUT_CYC);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  // Last stalled ACCESS cycle before the forced error
  assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Counter clears in SETUP and counts ACCESS cycles without pready
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == SETUP) begin
      to_cnt_d = '0;
    end else if (state_q == ACCESS && !pready && !to_hit) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Timeout counter register
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and registered-output logic for the transfer sequencer
  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    done_d      = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    arb_upd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          arb_upd = 1'b1;
          gidx_d  = arb_idx;
          for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
              paddr_d  = req_addr[i*ADDR_W +: ADDR_W];
              pwrite_d = req_write[i];
              pwdata_d = req_wdata[i*DATA_W +: DATA_W];
            end
          end
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done_d[gidx_q] = 1'b1;
          rsp_rdata_d    = pwrite_q ? '0 : prdata;
          rsp_err_d      = pslverr;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          state_d        = IDLE;
        end else if (to_hit) begin
          done_d[gidx_q] = 1'b1;
          rsp_err_d      = 1'b1;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State, payload latch and response registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      gidx_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign done      = done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
